// File: rtl/streaming_multi_core_collector.sv
// Reorder collector: buffers incoming graph words, dispatches them to the lowest-index idle core,
// gathers out-of-order core results and releases them strictly in acceptance order.
module streaming_multi_core_collector #(
    parameter int NCORES           = 2,
    parameter int GRAPH_WIDTH      = 128,
    parameter int EXTRA_DATA_WIDTH = 1,
    parameter int ADDR_WIDTH       = 5,
    parameter int SLACK            = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             isBotValid,
    input  logic [GRAPH_WIDTH-1:0]           graphIn,
    input  logic [EXTRA_DATA_WIDTH-1:0]      extraDataIn,
    output logic                             slowDownInput,
    input  logic [NCORES-1:0]                coreRequest,
    output logic [NCORES-1:0]                coreStart,
    output logic [GRAPH_WIDTH-1:0]           coreGraph,
    output logic [ADDR_WIDTH-1:0]            coreTag,
    input  logic [NCORES-1:0]                coreDone,
    input  logic [6*NCORES-1:0]              coreCount,
    input  logic [ADDR_WIDTH*NCORES-1:0]     coreTagOut,
    output logic                             resultValid,
    output logic [5:0]                       connectCount,
    output logic [EXTRA_DATA_WIDTH-1:0]      extraDataOut,
    output logic [ADDR_WIDTH:0]              occupancy,
    output logic [3:0]                       activityMeasure,
    output logic [1:0]                       errorFlags
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] SLOW_TH = PW'(DEPTH - SLACK);

    logic [GRAPH_WIDTH-1:0]      graph_mem [DEPTH];
    logic [EXTRA_DATA_WIDTH-1:0] extra_mem [DEPTH];
    logic [5:0]                  count_mem [DEPTH];

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, disp_ptr_q, disp_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]       done_q, done_d;
    logic [NCORES-1:0]      core_start_q;
    logic [GRAPH_WIDTH-1:0] core_graph_q;
    logic [ADDR_WIDTH-1:0]  core_tag_q;
    logic                   result_valid_q;
    logic [5:0]             connect_count_q;
    logic [EXTRA_DATA_WIDTH-1:0] extra_out_q;
    logic [3:0]             activity_q, activity_d;
    logic [1:0]             err_q;

    logic [PW-1:0]          occ, inflight;
    logic [ADDR_WIDTH-1:0]  wr_slot, disp_slot, rd_slot;
    logic                   accept, overflow_hit, dispatch, retire, tag_err, found;
    logic [NCORES-1:0]      grant, done_ok, core_in_range;
    logic [DEPTH-1:0]       set_mask;
    logic [5:0]             byp_count, head_count;

    logic [ADDR_WIDTH-1:0]  core_tag_w [NCORES];
    logic [5:0]             core_cnt_w [NCORES];

    assign occ          = wr_ptr_q - rd_ptr_q;
    assign inflight     = disp_ptr_q - rd_ptr_q;
    assign wr_slot      = wr_ptr_q[ADDR_WIDTH-1:0];
    assign disp_slot    = disp_ptr_q[ADDR_WIDTH-1:0];
    assign rd_slot      = rd_ptr_q[ADDR_WIDTH-1:0];
    assign accept       = isBotValid && (occ != DEPTH_P);
    assign overflow_hit = isBotValid && (occ == DEPTH_P);
    assign dispatch     = (disp_ptr_q != wr_ptr_q) && (|coreRequest);

    // Tag range test is done relative to the head so it survives pointer wrap.
    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
            logic [ADDR_WIDTH-1:0] off;
            assign core_tag_w[gi]    = coreTagOut[ADDR_WIDTH*gi +: ADDR_WIDTH];
            assign core_cnt_w[gi]    = coreCount[6*gi +: 6];
            assign off               = core_tag_w[gi] - rd_slot;
            assign core_in_range[gi] = {1'b0, off} < inflight;
        end
    endgenerate

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (coreRequest[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // set_mask also rejects a second completion for the same tag within one cycle.
    always_comb begin
        set_mask  = '0;
        done_ok   = '0;
        tag_err   = 1'b0;
        byp_count = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (coreDone[i]) begin
                if (core_in_range[i] && !done_q[core_tag_w[i]] && !set_mask[core_tag_w[i]]) begin
                    set_mask[core_tag_w[i]] = 1'b1;
                    done_ok[i] = 1'b1;
                    if (core_tag_w[i] == rd_slot) begin
                        byp_count = core_cnt_w[i];
                    end
                end else begin
                    tag_err = 1'b1;
                end
            end
        end
    end

    // A completion for the head retires in the same cycle, giving one-cycle done-to-result latency.
    assign retire     = done_q[rd_slot] | set_mask[rd_slot];
    assign head_count = set_mask[rd_slot] ? byp_count : count_mem[rd_slot];

    always_comb begin
        done_d = done_q | set_mask;
        if (accept) done_d[wr_slot] = 1'b0;
        if (retire) done_d[rd_slot] = 1'b0;
        wr_ptr_d   = wr_ptr_q + PW'(accept);
        disp_ptr_d = disp_ptr_q + PW'(dispatch);
        rd_ptr_d   = rd_ptr_q + PW'(retire);
    end

    always_comb begin
        activity_d = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (!coreRequest[i]) activity_d = activity_d + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            graph_mem[wr_slot] <= graphIn;
            extra_mem[wr_slot] <= extraDataIn;
        end
        for (int i = 0; i < NCORES; i++) begin
            if (done_ok[i]) count_mem[core_tag_w[i]] <= core_cnt_w[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            disp_ptr_q      <= '0;
            rd_ptr_q        <= '0;
            done_q          <= '0;
            core_start_q    <= '0;
            core_graph_q    <= '0;
            core_tag_q      <= '0;
            result_valid_q  <= 1'b0;
            connect_count_q <= '0;
            extra_out_q     <= '0;
            activity_q      <= '0;
            err_q           <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            disp_ptr_q     <= disp_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            done_q         <= done_d;
            core_start_q   <= dispatch ? grant : '0;
            if (dispatch) begin
                core_graph_q <= graph_mem[disp_slot];
                core_tag_q   <= disp_slot;
            end
            result_valid_q <= retire;
            if (retire) begin
                connect_count_q <= head_count;
                extra_out_q     <= extra_mem[rd_slot];
            end
            activity_q     <= activity_d;
            err_q          <= err_q | {tag_err, overflow_hit};
        end
    end

    assign slowDownInput   = occ > SLOW_TH;
    assign occupancy       = occ;
    assign coreStart       = core_start_q;
    assign coreGraph       = core_graph_q;
    assign coreTag         = core_tag_q;
    assign resultValid     = result_valid_q;
    assign connectCount    = connect_count_q;
    assign extraDataOut    = extra_out_q;
    assign activityMeasure = activity_q;
    assign errorFlags      = err_q;

endmodule

// File: tb/tb_streaming_multi_core_collector.sv
// Directed bench for the collector: a scoreboard of expected results in acceptance order,
// with simple core models that return a count derived from the graph they were given.
module tb_streaming_multi_core_collector;

    localparam int NC = 2;
    localparam int GW = 128;
    localparam int EW = 1;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              isBotValid;
    logic [GW-1:0]     graphIn;
    logic [EW-1:0]     extraDataIn;
    logic              slowDownInput;
    logic [NC-1:0]     coreRequest;
    logic [NC-1:0]     coreStart;
    logic [GW-1:0]     coreGraph;
    logic [AW-1:0]     coreTag;
    logic [NC-1:0]     coreDone;
    logic [6*NC-1:0]   coreCount;
    logic [AW*NC-1:0]  coreTagOut;
    logic              resultValid;
    logic [5:0]        connectCount;
    logic [EW-1:0]     extraDataOut;
    logic [AW:0]       occupancy;
    logic [3:0]        activityMeasure;
    logic [1:0]        errorFlags;

    always #5 clk = ~clk;

    streaming_multi_core_collector #(
        .NCORES(NC), .GRAPH_WIDTH(GW), .EXTRA_DATA_WIDTH(EW), .ADDR_WIDTH(AW), .SLACK(4)
    ) dut (
        .clk(clk), .rst(rst), .isBotValid(isBotValid), .graphIn(graphIn),
        .extraDataIn(extraDataIn), .slowDownInput(slowDownInput), .coreRequest(coreRequest),
        .coreStart(coreStart), .coreGraph(coreGraph), .coreTag(coreTag), .coreDone(coreDone),
        .coreCount(coreCount), .coreTagOut(coreTagOut), .resultValid(resultValid),
        .connectCount(connectCount), .extraDataOut(extraDataOut), .occupancy(occupancy),
        .activityMeasure(activityMeasure), .errorFlags(errorFlags)
    );

    typedef struct packed {
        logic [5:0]    cnt;
        logic [EW-1:0] ext;
    } exp_t;

    exp_t          exp_q [$];
    int            checks = 0;
    int            fails = 0;
    int            model_occ = 0;
    int            n_results = 0;
    bit            auto_mode = 0;
    bit            last_rv = 0;
    logic [GW-1:0] tag_graph [DEPTH];
    int            core_busy [NC];
    int            core_tag [NC];
    int            core_wait [NC];

    // Count a core model returns for a given graph.
    function automatic logic [5:0] cnt_of(input logic [GW-1:0] g);
        return g[5:0] ^ g[69:64];
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic issue_done(input int core, input int tag);
        coreDone[core] = 1'b1;
        coreTagOut[core*AW +: AW] = AW'(tag);
        coreCount[core*6 +: 6] = cnt_of(tag_graph[tag]);
    endtask

    task automatic monitor();
        exp_t e;
        isBotValid = 1'b0;
        coreDone   = '0;
        last_rv    = resultValid;
        if (resultValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", resultValid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result_count", connectCount, e.cnt);
                chk("result_extra", extraDataOut, e.ext);
                model_occ--;
                n_results++;
                $display("result %0d: count=%0h extra=%0h", n_results, connectCount, extraDataOut);
            end
        end
        chk("start_onehot", $countones(coreStart) <= 1, 1);
        for (int i = 0; i < NC; i++) begin
            if (coreStart[i] === 1'b1) begin
                tag_graph[coreTag] = coreGraph;
                $display("dispatch: core %0d tag %0d", i, coreTag);
                if (auto_mode) begin
                    chk("start_while_busy", core_busy[i], 0);
                    core_busy[i] = 1;
                    core_tag[i]  = int'(coreTag);
                    core_wait[i] = int'($urandom_range(0, 4));
                    coreRequest[i] = 1'b0;
                end
            end
        end
        if (auto_mode) begin
            for (int i = 0; i < NC; i++) begin
                if (core_busy[i] != 0) begin
                    if (core_wait[i] == 0) begin
                        issue_done(i, core_tag[i]);
                        core_busy[i] = 0;
                        coreRequest[i] = 1'b1;
                    end else begin
                        core_wait[i]--;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic send(input logic [GW-1:0] g, input logic [EW-1:0] x);
        exp_t e;
        graphIn     = g;
        extraDataIn = x;
        isBotValid  = 1'b1;
        if (model_occ < DEPTH) begin
            e.cnt = cnt_of(g);
            e.ext = x;
            exp_q.push_back(e);
            model_occ++;
        end
        step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        model_occ = 0;
        for (int i = 0; i < NC; i++) core_busy[i] = 0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    function automatic logic [GW-1:0] rnd_graph();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int sent;
        int r0;
        rst = 1'b1; isBotValid = 1'b0; graphIn = '0; extraDataIn = '0;
        coreRequest = '0; coreDone = '0; coreCount = '0; coreTagOut = '0;
        for (int i = 0; i < NC; i++) begin core_busy[i] = 0; core_tag[i] = 0; core_wait[i] = 0; end
        for (int i = 0; i < DEPTH; i++) tag_graph[i] = '0;

        // Reset state
        do_reset(3);
        rst = 1'b1;
        step();
        chk("rst_coreStart", coreStart, 0);
        chk("rst_resultValid", resultValid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_errorFlags", errorFlags, 0);
        chk("rst_activity", activityMeasure, 0);
        chk("rst_connectCount", connectCount, 0);
        chk("rst_extraDataOut", extraDataOut, 0);
        rst = 1'b0;

        // Single word: core0 takes it two cycles after acceptance, count 7 returns next cycle
        coreRequest = 2'b01;
        send(128'h7, 1'b1);
        chk("t1_no_bypass", coreStart, 0);
        chk("t1_occupancy", occupancy, 1);
        step();
        chk("t1_start", coreStart, 2'b01);
        chk("t1_tag", coreTag, 0);
        chk("t1_activity", activityMeasure, 1);
        step();
        chk("t1_start_pulse", coreStart, 0);
        issue_done(0, 0);
        step();
        chk("t1_rv", last_rv, 1);
        chk("t1_count", connectCount, 7);
        step();
        chk("t1_rv_off", last_rv, 0);
        chk("t1_count_hold", connectCount, 7);
        chk("t1_occ_empty", occupancy, 0);

        // Three words completed out of order (tags 1,2,3; done order 3,1,2)
        for (int k = 0; k < 3; k++) send(rnd_graph(), EW'(k));
        repeat (4) step();
        issue_done(0, 3);
        step();
        chk("t2_no_early_retire", last_rv, 0);
        issue_done(0, 1);
        step();
        chk("t2_rv_first", last_rv, 1);
        issue_done(0, 2);
        step();
        chk("t2_rv_second", last_rv, 1);
        step();
        chk("t2_rv_third", last_rv, 1);
        step();
        chk("t2_rv_idle", last_rv, 0);
        chk("t2_errors", errorFlags, 0);

        // Both cores complete in the same cycle (tags 4 and 5)
        send(rnd_graph(), 1'b0);
        send(rnd_graph(), 1'b1);
        repeat (4) step();
        issue_done(0, 4);
        issue_done(1, 5);
        step();
        chk("t3_rv_a", last_rv, 1);
        step();
        chk("t3_rv_b", last_rv, 1);
        step();
        chk("t3_rv_idle", last_rv, 0);
        chk("t3_errors", errorFlags, 0);

        // Fill to capacity with no dispatch, then overflow
        coreRequest = 2'b00;
        for (int k = 0; k < DEPTH; k++) begin
            send(rnd_graph(), EW'(k));
            chk("t4_occupancy", occupancy, k + 1);
            chk("t4_slowdown", slowDownInput, (k + 1) > 28);
        end
        send(rnd_graph(), 1'b1);
        chk("t4_occ_full", occupancy, DEPTH);
        chk("t4_overflow_flag", errorFlags, 2'b01);

        // Reset with entries in flight, then a stale completion
        do_reset(2);
        chk("t5_rst_errors", errorFlags, 0);
        coreRequest = 2'b01;
        for (int k = 0; k < 5; k++) send(rnd_graph(), EW'(k));
        repeat (4) step();
        chk("t5_outstanding", occupancy, 5);
        do_reset(1);
        chk("t5_occ_cleared", occupancy, 0);
        issue_done(0, 3);
        step();
        chk("t5_no_rv", last_rv, 0);
        chk("t5_tag_error", errorFlags, 2'b10);
        step();
        chk("t5_no_rv_late", last_rv, 0);
        chk("t5_start_idle", coreStart, 0);

        // 100 words with auto-completing cores and continuous retire, wrapping pointers
        do_reset(2);
        auto_mode = 1;
        coreRequest = 2'b11;
        sent = 0;
        r0 = n_results;
        for (int guard = 0; guard < 3000 && sent < 100; guard++) begin
            if (slowDownInput) begin
                step();
            end else begin
                send(rnd_graph(), EW'($urandom_range(0, 1)));
                sent++;
            end
        end
        for (int guard = 0; guard < 3000 && exp_q.size() > 0; guard++) step();
        repeat (3) step();
        chk("t6_sent", sent, 100);
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_results", n_results - r0, 100);
        chk("t6_errors", errorFlags, 0);
        chk("t6_occ_empty", occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/streaming_multi_core_collector.md
STREAMING_MULTI_CORE_COLLECTOR -- requirements
Module: streamingMultiCoreCollector

Interface
REQ-001 SHALL have parameter NCORES, default 2; number of attached count-connected cores, legal range 1..8.
REQ-002 SHALL have parameter GRAPH_WIDTH, default 128; graph word width.
REQ-003 SHALL have parameter EXTRA_DATA_WIDTH, default 1; sideband carried input to output.
REQ-004 SHALL have parameter ADDR_WIDTH, default 5; reorder depth DEPTH = 2^ADDR_WIDTH entries.
REQ-005 SHALL have parameter SLACK, default 4; almost-full margin, range 1..DEPTH-1.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port isBotValid  in  1  input word valid this cycle.
REQ-009 SHALL have port graphIn  in  GRAPH_WIDTH  graph to count.
REQ-010 SHALL have port extraDataIn  in  EXTRA_DATA_WIDTH  sideband.
REQ-011 SHALL have port slowDownInput  out  1  upstream throttle.
REQ-012 SHALL have port coreRequest  in  NCORES  core i idle and able to take a graph.
REQ-013 SHALL have port coreStart  out  NCORES  one-hot dispatch strobe.
REQ-014 SHALL have port coreGraph  out  GRAPH_WIDTH  shared dispatch graph bus.
REQ-015 SHALL have port coreTag  out  ADDR_WIDTH  shared dispatch tag bus.
REQ-016 SHALL have port coreDone  in  NCORES  core i result valid.
REQ-017 SHALL have port coreCount  in  6*NCORES  core i count at bits [6i+5:6i].
REQ-018 SHALL have port coreTagOut  in  ADDR_WIDTH*NCORES  core i returned tag.
REQ-019 SHALL have port resultValid  out  1  in-order result strobe.
REQ-020 SHALL have port connectCount  out  6  result count.
REQ-021 SHALL have port extraDataOut  out  EXTRA_DATA_WIDTH  sideband of the result.
REQ-022 SHALL have port occupancy  out  ADDR_WIDTH+1  entries outstanding (wrPtr-rdPtr).
REQ-023 SHALL have port activityMeasure  out  4  number of cores with coreRequest low, registered.
REQ-024 SHALL have port errorFlags  out  2  sticky {tagError, overflowError}.

Function
REQ-025 SHALL keep three ADDR_WIDTH+1-bit pointers wrPtr, dispPtr, rdPtr with rdPtr <= dispPtr <= wrPtr (modulo wrap); slot index = pointer[ADDR_WIDTH-1:0].
REQ-026 SHALL accept isBotValid when occupancy < DEPTH: write graph, extraData into slot wrPtr, clear its done bit, increment wrPtr.
REQ-027 SHALL, on isBotValid with occupancy == DEPTH, drop the word, leave pointers unchanged, set overflowError.
REQ-028 SHALL drive slowDownInput = (occupancy > DEPTH-SLACK), combinational from registered occupancy.
REQ-029 SHALL dispatch when dispPtr != wrPtr and any coreRequest bit set: the lowest-index requesting core, registered; next cycle coreStart one-hot for 1 cycle, coreGraph/coreTag = slot dispPtr; dispPtr increments; at most one dispatch per cycle.
REQ-030 SHALL make a word accepted in cycle N dispatchable no earlier than cycle N+1 (coreStart at N+2 minimum); no same-cycle bypass.
REQ-031 SHALL hold coreStart at 0 whenever no dispatch occurs; coreGraph/coreTag hold last value.
REQ-032 SHALL write every coreDone[i] in the same cycle (up to NCORES simultaneous writes): store count, set done bit of slot coreTagOut[i].
REQ-033 SHALL ignore a coreDone whose tag is not in [rdPtr, dispPtr) or whose done bit is already set, and set tagError.
REQ-034 SHALL retire when done bit of slot rdPtr is set: next cycle resultValid=1 with that slot's count and extraData; clear done bit; increment rdPtr; max one retire per cycle.
REQ-035 SHALL retire strictly in acceptance order regardless of completion order.
REQ-036 SHALL make minimum done-to-resultValid latency 1 cycle when the completed tag is the head.
REQ-037 SHALL leave occupancy unchanged on simultaneous accept and retire; pointer wrap from 2*DEPTH-1 to 0 is seamless.
REQ-038 SHALL hold connectCount/extraDataOut at last value while resultValid=0.

Reset
REQ-039 SHALL, on rst, zero all pointers, done bits, coreStart, resultValid, occupancy, activityMeasure, errorFlags, connectCount, extraDataOut.
REQ-040 SHALL give rst priority over accept, dispatch, done and retire in the same cycle; in-flight entries are discarded.
REQ-041 SHALL, after rst, flag any coreDone with a stale tag as tagError per REQ-033.

Verification
REQ-042 SHALL pass: single word, NCORES=2, core0 requesting -> coreStart=2'b01 at cycle 2, tag 0; coreDone count 7 -> resultValid, connectCount=7 next cycle.
REQ-043 SHALL pass: tags 0,1,2 to cores; done order 2,0,1 -> resultValid counts in order 0,1,2, last retire one cycle after tag 1 done.
REQ-044 SHALL pass: 32 accepts without dones (ADDR_WIDTH=5, SLACK=4) -> slowDownInput=1 from occupancy 29; 33rd dropped, errorFlags=2'b01.
REQ-045 SHALL pass: both cores coreDone same cycle, tags 0 and 1 -> both stored, resultValid two consecutive cycles.
REQ-046 SHALL pass: 100 words with continuous retire -> pointers wrap, all 100 results in order, no error.
REQ-047 SHALL pass: rst with 5 outstanding, then coreDone tag 3 -> no resultValid, errorFlags=2'b10.
